// File: rtl/ysyx_22050612_idu_stage.sv
// RV32I/RV64I decode stage: combinational decode of the offered instruction,
// results queued in a 1- or 2-entry skid buffer toward the EXU.
module ysyx_22050612_idu_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_op,
  output logic            out_illegal,
  output logic            out_ebreak,
  output logic [31:0]     stall_cnt
);

  localparam bit RV64 = (XLEN == 64);
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [6:0] {
    OP_NONE   = 7'd0,
    OP_LUI    = 7'd1,
    OP_AUIPC  = 7'd2,
    OP_JAL    = 7'd3,
    OP_JALR   = 7'd4,
    OP_BEQ    = 7'd5,
    OP_BNE    = 7'd6,
    OP_LW     = 7'd13,
    OP_ADDI   = 7'd19,
    OP_SLTIU  = 7'd21,
    OP_ADD    = 7'd36,
    OP_SUB    = 7'd37,
    OP_LD     = 7'd42,
    OP_SD     = 7'd43,
    OP_ADDIW  = 7'd47,
    OP_ADDW   = 7'd49,
    OP_EBREAK = 7'd63
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [6:0]      op;
    logic            illegal;
    logic            ebreak;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  op_e        op;
  imm_fmt_e   fmt;
  logic [31:0] imm32;
  entry_t     dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  always_comb begin
    op  = OP_NONE;
    fmt = IMM_NONE;
    case (opcode)
      7'b0110111: begin op = OP_LUI;   fmt = IMM_U; end
      7'b0010111: begin op = OP_AUIPC; fmt = IMM_U; end
      7'b1101111: begin op = OP_JAL;   fmt = IMM_J; end
      7'b1100111: if (funct3 == 3'b000) begin op = OP_JALR; fmt = IMM_I; end
      7'b1100011: begin
        if (funct3 == 3'b000)      begin op = OP_BEQ; fmt = IMM_B; end
        else if (funct3 == 3'b001) begin op = OP_BNE; fmt = IMM_B; end
      end
      7'b0000011: begin
        if (funct3 == 3'b010)              begin op = OP_LW; fmt = IMM_I; end
        else if (funct3 == 3'b011 && RV64) begin op = OP_LD; fmt = IMM_I; end
      end
      7'b0100011: if (funct3 == 3'b011 && RV64) begin op = OP_SD; fmt = IMM_S; end
      7'b0010011: begin
        if (funct3 == 3'b000)      begin op = OP_ADDI;  fmt = IMM_I; end
        else if (funct3 == 3'b011) begin op = OP_SLTIU; fmt = IMM_I; end
      end
      7'b0011011: if (funct3 == 3'b000 && RV64) begin op = OP_ADDIW; fmt = IMM_I; end
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) op = OP_SUB;
      end
      7'b0111011: if (funct3 == 3'b000 && funct7 == 7'b0000000 && RV64) op = OP_ADDW;
      7'b1110011: if (in_inst == EBREAK_WORD) op = OP_EBREAK;
      default: ;
    endcase
  end

  // Immediates are formed at 32 bits, then sign-extended to XLEN in one place.
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      IMM_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IMM_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
      IMM_U: imm32 = {in_inst[31:12], 12'b0};
      IMM_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = in_inst[11:7];
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.imm     = XLEN'($signed(imm32));
    dec.op      = op;
    dec.illegal = (op == OP_NONE);
    dec.ebreak  = (in_inst == EBREAK_WORD);
  end

  entry_t     slot0;
  entry_t     slot1;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && in_ready && !flush;

  // Depth 2 breaks the out_ready -> in_ready path; depth 1 needs it to stream.
  always_comb begin
    in_ready = 1'b0;
    if (DEPTH == 1) in_ready = rst_n && (!out_valid || out_ready);
    else            in_ready = rst_n && (count < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      slot0     <= '0;
      slot1     <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count == 2'd2) begin
              slot0 <= slot1;
              slot1 <= dec;
            end else begin
              slot0 <= dec;
            end
          end
          2'b10: begin
            if (count == 2'd0) slot0 <= dec;
            else               slot1 <= dec;
            count <= count + 2'd1;
          end
          2'b01: begin
            slot0 <= slot1;
            count <= count - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_pc      = slot0.pc;
  assign out_rd      = slot0.rd;
  assign out_rs1     = slot0.rs1;
  assign out_rs2     = slot0.rs2;
  assign out_imm     = slot0.imm;
  assign out_op      = slot0.op;
  assign out_illegal = slot0.illegal;
  assign out_ebreak  = slot0.ebreak;

endmodule

// File: doc/ysyx_22050612_idu_stage.md
# ysyx_22050612_idu_stage

Registered RV32I/RV64I decode stage with valid/ready handshakes on both sides, sitting between the IFU and the EXU. It accepts one instruction and PC per handshake and decodes fields, the format-selected sign-extended immediate, an op index, and illegal/ebreak flags. Results are held in a parametrised skid buffer (depth 1 or 2). It supports pipeline flush and counts backpressure stall cycles for performance bring-up.

## Interface
- XLEN, 64: datapath width, 32 or 64; controls immediate width and RV64-only legality.
- DEPTH, 2: output buffer entries, 1 or 2.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  in  1  discard all buffered entries and any input this cycle.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EXU consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
- out_imm  out  XLEN  selected immediate.
- out_op  out  7  op index, 0 = none/illegal.
- out_illegal  out  1  unrecognised encoding, or RV64-only op with XLEN=32.
- out_ebreak  out  1  inst == 0x00100073.
- stall_cnt  out  32  saturating count of cycles with out_valid && !out_ready.

## Operation
- Op index values:
  - lui 1, auipc 2, jal 3, jalr 4, beq 5, bne 6
  - lw 13, addi 19, sltiu 21, add 36, sub 37
  - ld 42, sd 43, addiw 47, addw 49, ebreak 63
  - Everything else decodes to 0 with out_illegal=1.
- Matching:
  - U/J formats match on opcode only.
  - I/S/B formats match on funct3 and opcode.
  - R format matches on funct7, funct3 and opcode.
  - ebreak matches the full 32-bit word.
- RV64-only ops are ld, sd, addiw, addw. With XLEN=32 they give op 0 and illegal=1.
- Immediate sign bit is inst[31] for every format. Results are sign-extended to XLEN.
  - I: jalr, loads, addi, sltiu, addiw.
  - S: sd.
  - B: beq, bne.
  - U: lui, auipc (inst[31:12]<<12).
  - J: jal.
  - R, ebreak and illegal: 0.
- Decode is combinational on in_inst. The result is written into the buffer on accept (in_valid && in_ready && !flush).
- Buffer is a FIFO; entries leave in acceptance order.
  - Head is presented on the out_* ports.
  - Head pops on out_valid && out_ready.
- DEPTH=1:
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Simultaneous pop and accept replaces the entry in the same cycle.
- DEPTH=2:
  - in_ready = (count < 2), driven from registers only; no combinational path from out_ready.
  - Pop and accept together leave the count unchanged; the second entry moves to head.
  - Accept with count 0 goes to head. Accept with count 1 and no pop goes to the second slot.
- Flush:
  - Count goes to 0 on the next edge.
  - Any same-cycle input is dropped, and any same-cycle pop is irrelevant.
  - stall_cnt is not cleared.
- stall_cnt increments on every cycle where out_valid && !out_ready. It saturates at 0xFFFFFFFF and clears only on reset.

## Timing
- Reset (rst_n low at an edge):
  - Count 0, out_valid 0, stall_cnt 0.
  - All out_* data ports 0.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N, given the buffer was empty; no bypass of in_* to out_*.
- Payload: out_* data fields are stable while out_valid && !out_ready. Values when out_valid=0 are don't-care for the EXU; the bench checks them only at reset.
- A reset asserted mid-stream discards all entries exactly as flush does, and also clears stall_cnt.

## Test plan
- Basic decode: in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000 → one cycle later:
  - out_op=19, rd=1, rs1=0, imm=5, illegal=0, out_pc=0x80000000.
- B-type sign: in_inst=0xFE209EE3 (bne x1,x2,-4) → out_op=6, rs1=1, rs2=2, imm=0xFFFFFFFFFFFFFFFC.
- ebreak and illegal:
  - 0x00100073 → op=63, ebreak=1.
  - 0x00000000 → op=0, illegal=1.
  - XLEN=32 build with 0x00013083 (ld) → op=0, illegal=1.
- Backpressure, DEPTH=2: out_ready=0, three back-to-back instructions offered →
  - Two are accepted; in_ready=0 on the third offer.
  - stall_cnt increments once per held cycle.
  - Raising out_ready drains A, B, then C in order, with no loss or duplication.
- Flush: buffer holds 2 entries and in_valid=1 with flush=1 → next cycle out_valid=0, the input is not accepted, and in_ready=1.
- Reset mid-operation: rst_n=0 for one edge with 2 entries and stall_cnt=7 → out_valid=0, stall_cnt=0, in_ready=0 during reset and 1 after release.
